// File: rtl/debounced_edge_detector_if.sv
// rtl/debounced_edge_detector_if.sv - raw sensor inputs and debounced level/pulse outputs
interface debounced_edge_detector_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic [CHANNELS-1:0] edge_pulse;

    // Sensor side / consumer: drives raw inputs, observes levels and pulses.
    modport master (
        output raw_in,
        input  stable,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_pulse
    );

    // Detector side.
    modport slave (
        input  raw_in,
        output stable,
        output rise_pulse,
        output fall_pulse,
        output edge_pulse
    );
endinterface

// File: rtl/debounced_edge_detector.sv
// rtl/debounced_edge_detector.sv - per-channel synchroniser, debouncer and registered edge pulses
module debounced_edge_detector #(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    debounced_edge_detector_if.slave bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Mode 2 and any larger value select both polarities for edge_pulse.
    localparam logic SEL_RISE = (EDGE_MODE != 1);
    localparam logic SEL_FALL = (EDGE_MODE != 0);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_stable;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_edge;

        logic w_sync;
        logic w_accept;
        logic w_rise_nxt;
        logic w_fall_nxt;

        assign w_sync     = r_sync[SYNC_STAGES-1];
        // The new level is accepted on the cycle the counter has already seen
        // DEBOUNCE_CYCLES-1 consecutive mismatches and the mismatch persists.
        assign w_accept   = (w_sync != r_stable) && (r_cnt == CNT_LAST);
        assign w_rise_nxt = w_accept & w_sync;
        assign w_fall_nxt = w_accept & ~w_sync;

        // Shift the asynchronous input through the synchroniser chain.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_in[c]};
            end
        end

        // Count consecutive mismatches; any return to the stable level restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Register the pulses so they line up with the cycle stable takes its new value.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_edge <= 1'b0;
            end else begin
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                r_edge <= (SEL_RISE & w_rise_nxt) | (SEL_FALL & w_fall_nxt);
            end
        end

        assign bus.stable[c]     = r_stable;
        assign bus.rise_pulse[c] = r_rise;
        assign bus.fall_pulse[c] = r_fall;
        assign bus.edge_pulse[c] = r_edge;
    end
endmodule

// File: tb/tb_debounced_edge_detector.sv
// tb/tb_debounced_edge_detector.sv - directed table-driven bench for debounced_edge_detector
module tb_debounced_edge_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] raw = 2'b11;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    debounced_edge_detector_if #(.CHANNELS(2)) bus0 ();
    debounced_edge_detector_if #(.CHANNELS(2)) bus1 ();
    debounced_edge_detector_if #(.CHANNELS(2)) bus2 ();
    debounced_edge_detector_if #(.CHANNELS(2)) busd ();

    assign bus0.raw_in = raw;
    assign bus1.raw_in = raw;
    assign bus2.raw_in = raw;
    assign busd.raw_in = raw;

    debounced_edge_detector #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    debounced_edge_detector #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    debounced_edge_detector #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    debounced_edge_detector #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0))
        dutd (.clk(clk), .reset(reset), .bus(busd));

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [1:0] stb;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic [1:0] v,
                       input logic [1:0] s, input logic [1:0] ri, input logic [1:0] fa);
        vec_t e;
        e.rst  = r;
        e.raw  = v;
        e.stb  = s;
        e.rise = ri;
        e.fall = fa;
        for (int k = 0; k < n; k++) vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [1:0] v);
        @(negedge clk);
        reset = r;
        raw   = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_d_stb [5];
        logic [1:0] exp_d_rise[5];
        logic [1:0] exp_d_fall[5];

        // rst, raw, stable, rise, fall -- one row per clock edge, DEBOUNCE_CYCLES=4
        add(3, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);  // reset held with inputs high
        add(5, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);  // requalification after release
        add(1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00);  // 6th edge: both rise
        add(1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
        add(5, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00);  // both fall
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(3, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);  // 3-cycle glitch on ch0
        add(5, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(4, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);  // 4-cycle pulse on ch0 is accepted
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00);
        add(3, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(5, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);  // clean held edge on ch0
        add(1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00);
        add(1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
        add(5, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        add(5, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);  // simultaneous 00->11
        add(1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].raw);
            chk("stable",     i, bus0.stable,     vecs[i].stb);
            chk("rise",       i, bus0.rise_pulse, vecs[i].rise);
            chk("fall",       i, bus0.fall_pulse, vecs[i].fall);
            chk("edge_mode0", i, bus0.edge_pulse, vecs[i].rise);
            chk("edge_mode1", i, bus1.edge_pulse, vecs[i].fall);
            chk("edge_mode2", i, bus2.edge_pulse, vecs[i].rise | vecs[i].fall);
        end

        // Reset mid-debounce: ch1 counter reaches 2, then a one-cycle reset discards it.
        step(1'b1, 2'b00);
        chk("mid_rst_clear", 0, bus0.stable, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 2'b10);
            chk("mid_rst_count", i, bus0.stable, 2'b00);
        end
        step(1'b1, 2'b10);
        chk("mid_rst_stable", 5, bus0.stable,     2'b00);
        chk("mid_rst_rise",   5, bus0.rise_pulse, 2'b00);
        for (int i = 6; i <= 11; i++) begin
            step(1'b0, 2'b10);
            chk("mid_rst_rise",    i, bus0.rise_pulse, (i == 11) ? 2'b10 : 2'b00);
            chk("mid_rst_stable",  i, bus0.stable,     (i == 11) ? 2'b10 : 2'b00);
            chk("d1_requal_rise",  i, busd.rise_pulse, (i == 8)  ? 2'b10 : 2'b00);
        end

        // One-cycle raw pulse on ch0: accepted with DEBOUNCE_CYCLES=1, ignored with 4.
        exp_d_stb  = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10};
        exp_d_rise = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        exp_d_fall = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i == 0) ? 2'b11 : 2'b10);
            if (i < 5) begin
                chk("d1_stable", i, busd.stable,     exp_d_stb[i]);
                chk("d1_rise",   i, busd.rise_pulse, exp_d_rise[i]);
                chk("d1_fall",   i, busd.fall_pulse, exp_d_fall[i]);
            end
            chk("d4_glitch_stable", i, bus0.stable,     2'b10);
            chk("d4_glitch_rise",   i, bus0.rise_pulse, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
